// File: rtl/scumv_packet_framer.sv
// Host-side framer for the SCuM-V controller byte protocol: prefix + payload out, mode-specific response in.
// Optional feature macro: SCUMV_FRAMER_STRAY_CNT_EN (saturating count of rx bytes received outside RESP).
module scumv_packet_framer #(
  parameter int ASC_PAYLOAD_BYTES = 22,
  parameter int STL_PAYLOAD_BYTES = 16,
  parameter int ASC_RESP_BYTES    = 1,
  parameter int STL_RESP_BYTES    = 16,
  parameter int TIMEOUT_CYCLES    = 1_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_mode,
  input  logic [7:0] pl_data,
  input  logic       pl_valid,
  output logic       pl_ready,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       rx_ready,
  output logic [7:0] resp_data,
  output logic       resp_valid,
  input  logic       resp_ready,
  output logic       resp_last,
  output logic       busy,
  output logic       timeout,
  output logic [7:0] stray_count,
  output logic [1:0] state_dbg
);

  // All handshakes (cmd, pl, tx, rx, resp): a transfer happens on a rising clk edge where valid
  // and ready are both high; once raised, valid holds with stable data until that transfer.

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PREFIX  = 2'd1,
    ST_PAYLOAD = 2'd2,
    ST_RESP    = 2'd3
  } state_t;

  localparam int TO_W = $clog2(TIMEOUT_CYCLES);
  // Leaving on the idle cycle that would bring the counter to TIMEOUT_CYCLES-1.
  localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT_CYCLES - 2);

  state_t          state_q, state_d;
  logic            mode_q, mode_d;
  logic [1:0]      idx_q, idx_d;
  logic [7:0]      cnt_q, cnt_d;
  logic [TO_W-1:0] to_q, to_d;
  logic            timeout_q, timeout_d;
  logic [7:0]      pl_last;
  logic [7:0]      rs_last;

  assign pl_last = mode_q ? 8'(STL_PAYLOAD_BYTES - 1) : 8'(ASC_PAYLOAD_BYTES - 1);
  assign rs_last = mode_q ? 8'(STL_RESP_BYTES - 1)    : 8'(ASC_RESP_BYTES - 1);

  function automatic logic [7:0] prefix_byte(input logic mode, input logic [1:0] idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = mode ? 8'h73 : 8'h61;
      2'd1:    b = mode ? 8'h74 : 8'h73;
      2'd2:    b = mode ? 8'h6C : 8'h63;
      default: b = 8'h2B;
    endcase
    return b;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      mode_q    <= 1'b0;
      idx_q     <= 2'd0;
      cnt_q     <= 8'd0;
      to_q      <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      to_q      <= to_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    to_d       = to_q;
    timeout_d  = timeout_q;
    cmd_ready  = 1'b0;
    pl_ready   = 1'b0;
    tx_valid   = 1'b0;
    tx_data    = 8'd0;
    rx_ready   = 1'b1;
    resp_valid = 1'b0;
    resp_data  = 8'd0;
    resp_last  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          mode_d    = cmd_mode;
          idx_d     = 2'd0;
          cnt_d     = 8'd0;
          timeout_d = 1'b0;
          state_d   = ST_PREFIX;
        end
      end
      ST_PREFIX: begin
        tx_valid = 1'b1;
        tx_data  = prefix_byte(mode_q, idx_q);
        if (tx_ready) begin
          idx_d = idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            cnt_d   = 8'd0;
            state_d = ST_PAYLOAD;
          end
        end
      end
      ST_PAYLOAD: begin
        tx_valid = pl_valid;
        tx_data  = pl_data;
        pl_ready = tx_ready;
        if (pl_valid && tx_ready) begin
          cnt_d = cnt_q + 8'd1;
          if (cnt_q == pl_last) begin
            cnt_d   = 8'd0;
            to_d    = '0;
            state_d = ST_RESP;
          end
        end
      end
      ST_RESP: begin
        rx_ready   = resp_ready;
        resp_valid = rx_valid;
        resp_data  = rx_data;
        resp_last  = (cnt_q == rs_last);
        // A byte arriving on the would-be timeout cycle wins over the timeout.
        if (rx_valid && resp_ready) begin
          cnt_d = cnt_q + 8'd1;
          to_d  = '0;
          if (cnt_q == rs_last) begin
            state_d = ST_IDLE;
          end
        end else if (to_q == TO_LIMIT) begin
          to_d      = '0;
          timeout_d = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          to_d = to_q + TO_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy      = (state_q != ST_IDLE);
  assign timeout   = timeout_q;
  assign state_dbg = state_q;

`ifdef SCUMV_FRAMER_STRAY_CNT_EN
  logic [7:0] stray_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      stray_q <= 8'd0;
    end else if (rx_valid && (state_q != ST_RESP) && (stray_q != 8'hFF)) begin
      stray_q <= stray_q + 8'd1;
    end
  end

  assign stray_count = stray_q;
`else
  assign stray_count = 8'd0;
`endif

endmodule

// File: tb/tb_scumv_packet_framer.sv
// Directed bench for scumv_packet_framer: idle-output table, transaction table, stray and reset sequences.
module tb_scumv_packet_framer;

  localparam int ASC_PL = 22;
  localparam int STL_PL = 16;
  localparam int ASC_RS = 1;
  localparam int STL_RS = 16;
  localparam int TO     = 100;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       cmd_valid = 1'b0, cmd_ready, cmd_mode = 1'b0;
  logic [7:0] pl_data = 8'd0;
  logic       pl_valid = 1'b0, pl_ready;
  logic [7:0] tx_data;
  logic       tx_valid, tx_ready = 1'b1;
  logic [7:0] rx_data = 8'd0;
  logic       rx_valid = 1'b0, rx_ready;
  logic [7:0] resp_data;
  logic       resp_valid, resp_ready = 1'b1, resp_last;
  logic       busy, timeout;
  logic [7:0] stray_count;
  logic [1:0] state_dbg;

  scumv_packet_framer #(
    .ASC_PAYLOAD_BYTES(ASC_PL), .STL_PAYLOAD_BYTES(STL_PL),
    .ASC_RESP_BYTES(ASC_RS), .STL_RESP_BYTES(STL_RS), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_mode(cmd_mode),
    .pl_data(pl_data), .pl_valid(pl_valid), .pl_ready(pl_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .resp_data(resp_data), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_last(resp_last), .busy(busy), .timeout(timeout),
    .stray_count(stray_count), .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;
  int exp_stray = 0;
  bit last_to = 1'b0;

  logic [7:0] exp_q[$];
  logic [7:0] exp_rsp_q[$];

  task automatic idle_inputs();
    cmd_valid = 1'b0; pl_valid = 1'b0; pl_data = 8'd0;
    rx_valid = 1'b0; rx_data = 8'd0; tx_ready = 1'b1; resp_ready = 1'b1;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    exp_stray = 0;
    last_to = 1'b0;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int stray_expect(input int cur, input int n);
`ifdef SCUMV_FRAMER_STRAY_CNT_EN
    return (cur + n > 255) ? 255 : cur + n;
`else
    return (cur + n > 255) ? 0 : 0 * n;
`endif
  endfunction

  // ---------------- driver tasks ----------------
  task automatic send_stray(input int n);
    for (int i = 0; i < n; i++) begin
      rx_valid = 1'b1;
      rx_data  = 8'(i);
      @(negedge clk);
      check("stray_rx_ready", rx_ready, 1'b1);
      @(posedge clk); #1;
    end
    rx_valid = 1'b0;
    exp_stray = stray_expect(exp_stray, n);
  endtask

  // One transaction, driven and scored cycle by cycle. Inputs change at posedge+1, outputs are
  // sampled at negedge, and a sampled valid&&ready pair is the transfer at the next posedge.
  task automatic run_txn(input logic mode, input bit tx_bp, input bit rsp_bp, input int n_rx,
                         input int abort_pl, input bit stray_acc, input bit exp_to, input bit chk_lat);
    int n_pl, n_rs, pl_idx, rx_idx, rsp_cnt, stall, c_acc, c_last, c_done;
    bit accepted, aborted, pl_hs, rsp_hs;
    logic [7:0] pl[$];
    logic [7:0] rs[$];
    logic [7:0] b;
    n_pl = mode ? STL_PL : ASC_PL;
    n_rs = mode ? STL_RS : ASC_RS;
    pl_idx = 0; rx_idx = 0; rsp_cnt = 0; stall = 0;
    c_acc = -1; c_last = -1; c_done = -1;
    accepted = 1'b0; aborted = 1'b0;
    exp_q.delete(); exp_rsp_q.delete();
    if (mode) begin
      exp_q.push_back(8'h73); exp_q.push_back(8'h74); exp_q.push_back(8'h6C); exp_q.push_back(8'h2B);
    end else begin
      exp_q.push_back(8'h61); exp_q.push_back(8'h73); exp_q.push_back(8'h63); exp_q.push_back(8'h2B);
    end
    for (int i = 0; i < n_pl; i++) begin
      b = mode ? 8'(8'h80 + i) : 8'(i);
      pl.push_back(b);
      exp_q.push_back(b);
    end
    for (int i = 0; i < n_rs; i++) begin
      b = mode ? 8'(8'hC0 + i) : 8'(8'hA5 + i);
      rs.push_back(b);
      if (i < n_rx) exp_rsp_q.push_back(b);
    end
    cmd_valid = 1'b1; cmd_mode = mode;
    pl_valid = 1'b1; pl_data = pl[0];
    tx_ready = 1'b1; resp_ready = !rsp_bp;
    rx_valid = stray_acc; rx_data = 8'h5A;
    if (stray_acc) exp_stray = stray_expect(exp_stray, 1);
    for (int budget = 0; budget < 2000; budget++) begin
      @(negedge clk);
      if (cmd_valid && cmd_ready) begin
        accepted = 1'b1;
        c_acc = cyc;
        check("timeout_hold", timeout, last_to);
      end else if (accepted && cmd_ready) begin
        c_done = cyc;
        break;
      end
      if (accepted && cyc == c_acc + 1) check("timeout_clr", timeout, 1'b0);
      if (tx_valid && tx_ready) begin
        if (exp_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL tx_extra: got unexpected byte %0h, expected none", tx_data);
        end else check("tx_byte", tx_data, exp_q.pop_front());
      end
      pl_hs  = pl_valid && pl_ready;
      rsp_hs = resp_valid && resp_ready;
      if (rsp_hs) begin
        if (exp_rsp_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL resp_extra: got unexpected byte %0h, expected none", resp_data);
        end else check("resp_byte", resp_data, exp_rsp_q.pop_front());
        check("resp_last", resp_last, (rsp_cnt == n_rs - 1));
        rsp_cnt++;
        if (rsp_cnt == n_rx) c_last = cyc;
      end
      @(posedge clk); #1;
      if (accepted) cmd_valid = 1'b0;
      if (pl_hs) pl_idx++;
      pl_valid = (pl_idx < n_pl);
      if (pl_valid) pl_data = pl[pl_idx];
      else pl_data = 8'd0;
      if (abort_pl > 0 && pl_idx == abort_pl) begin
        aborted = 1'b1;
        break;
      end
      if (tx_bp) tx_ready = ~tx_ready;
      if (rsp_hs) begin
        rx_idx++;
        stall = 0;
      end
      rx_valid = (pl_idx == n_pl) && (rx_idx < n_rx);
      if (rx_valid) rx_data = rs[rx_idx];
      else rx_data = 8'd0;
      if (rsp_bp) begin
        resp_ready = (stall >= 3);
        if (rx_valid && !resp_ready) stall++;
      end
    end
    if (aborted) begin
      pl_valid = 1'b0;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      check("abort_state", state_dbg, 2'd0);
      check("abort_tx_valid", tx_valid, 1'b0);
      check("abort_pl_ready", pl_ready, 1'b0);
      check("abort_cmd_ready", cmd_ready, 1'b1);
      check("abort_timeout", timeout, 1'b0);
      exp_stray = 0;
      last_to = 1'b0;
      @(posedge clk); #1;
      idle_inputs();
      return;
    end
    idle_inputs();
    check("txn_done", (c_done >= 0), 1'b1);
    check("tx_remaining", exp_q.size(), 0);
    check("resp_count", rsp_cnt, n_rx);
    check("timeout_flag", timeout, exp_to);
    check("end_busy", busy, 1'b0);
    if (chk_lat) check("latency", c_done - c_acc, 1 + 4 + n_pl + n_rs);
    // The 5th response transfer's edge and the edge into IDLE lie TO-1 edges apart.
    if (exp_to) check("timeout_delay", c_done - c_last, TO);
    last_to = exp_to;
    @(posedge clk); #1;
  endtask

  // ---------------- vector tables ----------------
  typedef struct {
    logic       pl_valid;
    logic [7:0] pl_data;
    logic       tx_ready;
    logic       resp_ready;
    logic       exp_cmd_ready;
    logic       exp_tx_valid;
    logic [7:0] exp_tx_data;
    logic       exp_pl_ready;
    logic       exp_rx_ready;
    logic       exp_resp_valid;
    logic [7:0] exp_resp_data;
    logic       exp_resp_last;
    logic       exp_busy;
    logic [1:0] exp_state;
  } idle_vec_t;

  typedef struct {
    logic mode;
    bit   tx_bp;
    bit   rsp_bp;
    int   n_rx;
    bit   exp_to;
    bit   chk_lat;
  } txn_vec_t;

  idle_vec_t iv[3];
  txn_vec_t  tv[5];

  initial begin
    iv[0] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 2'd0};
    iv[1] = '{1'b1, 8'hE7, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 2'd0};
    iv[2] = '{1'b1, 8'h3C, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 2'd0};
    tv[0] = '{1'b0, 1'b0, 1'b0, ASC_RS, 1'b0, 1'b1};
    tv[1] = '{1'b1, 1'b1, 1'b1, STL_RS, 1'b0, 1'b0};
    tv[2] = '{1'b1, 1'b0, 1'b0, 5,      1'b1, 1'b0};
    tv[3] = '{1'b0, 1'b0, 1'b0, ASC_RS, 1'b0, 1'b1};
    tv[4] = '{1'b1, 1'b0, 1'b0, STL_RS, 1'b0, 1'b1};

    do_reset();
    for (int i = 0; i < 3; i++) begin
      pl_valid = iv[i].pl_valid; pl_data = iv[i].pl_data;
      tx_ready = iv[i].tx_ready; resp_ready = iv[i].resp_ready;
      @(negedge clk);
      check("idle_cmd_ready", cmd_ready, iv[i].exp_cmd_ready);
      check("idle_tx_valid", tx_valid, iv[i].exp_tx_valid);
      check("idle_tx_data", tx_data, iv[i].exp_tx_data);
      check("idle_pl_ready", pl_ready, iv[i].exp_pl_ready);
      check("idle_rx_ready", rx_ready, iv[i].exp_rx_ready);
      check("idle_resp_valid", resp_valid, iv[i].exp_resp_valid);
      check("idle_resp_data", resp_data, iv[i].exp_resp_data);
      check("idle_resp_last", resp_last, iv[i].exp_resp_last);
      check("idle_busy", busy, iv[i].exp_busy);
      check("idle_state", state_dbg, iv[i].exp_state);
      check("idle_timeout", timeout, 1'b0);
      check("idle_stray", stray_count, 8'd0);
      @(posedge clk); #1;
    end
    idle_inputs();

    for (int i = 0; i < 5; i++)
      run_txn(tv[i].mode, tv[i].tx_bp, tv[i].rsp_bp, tv[i].n_rx, 0, 1'b0, tv[i].exp_to, tv[i].chk_lat);

    // Two strays in IDLE, a third on the cmd-accept cycle, then an ASC transaction.
    send_stray(2);
    run_txn(1'b0, 1'b0, 1'b0, ASC_RS, 0, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    check("stray_3", stray_count, 8'(exp_stray));
    @(posedge clk); #1;
    send_stray(300);
    @(negedge clk);
    check("stray_sat", stray_count, 8'(exp_stray));
    @(posedge clk); #1;

    // Reset after the 7th payload byte, then a clean ASC transaction.
    run_txn(1'b0, 1'b0, 1'b0, ASC_RS, 7, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check("post_reset_stray", stray_count, 8'd0);
    @(posedge clk); #1;
    run_txn(1'b0, 1'b0, 1'b0, ASC_RS, 0, 1'b0, 1'b0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/scumv_packet_framer.md
# scumv_packet_framer

Host-side initiator for the SCuM-V controller byte protocol. It takes a mode request and a payload byte stream, emits the 4-byte prefix ("asc+" = 61 73 63 2B, "stl+" = 73 74 6C 2B) followed by the payload toward a UART transmitter, then collects the mode-specific response bytes from a UART receiver and delivers them upstream. It sits between a command source (soft CPU, test sequencer, or loopback harness) and a byte-level UART TX/RX pair, mirroring the controller's prefix demultiplexer.

## Interface
- ASC_PAYLOAD_BYTES, 22, payload bytes sent after "asc+" (legal 1..255)
- STL_PAYLOAD_BYTES, 16, payload bytes sent after "stl+" (legal 1..255)
- ASC_RESP_BYTES, 1, response bytes expected in ASC mode (legal 1..255)
- STL_RESP_BYTES, 16, response bytes expected in STL mode (legal 1..255)
- TIMEOUT_CYCLES, 1_000_000, max idle clk cycles between response bytes (legal ≥2)

- clk  in  1  clock
- reset  in  1  synchronous, active-high
- cmd_valid / cmd_ready  in / out  1 / 1  transaction request handshake
- cmd_mode  in  1  0 = ASC, 1 = STL; sampled on cmd handshake
- pl_data  in  8  payload byte
- pl_valid / pl_ready  in / out  1 / 1  payload handshake
- tx_data  out  8  byte to UART transmitter
- tx_valid / tx_ready  out / in  1 / 1  transmitter handshake
- rx_data  in  8  byte from UART receiver
- rx_valid / rx_ready  in / out  1 / 1  receiver handshake
- resp_data  out  8  response byte
- resp_valid / resp_ready  out / in  1 / 1  response handshake
- resp_last  out  1  high with final response byte of a transaction
- busy  out  1  high in every state except IDLE
- timeout  out  1  sticky: last transaction aborted waiting for a response
- stray_count  out  8  bytes received outside RESP (see Configuration)
- state_dbg  out  2  current state encoding

## Operation
- States: IDLE=0, PREFIX=1, PAYLOAD=2, RESP=3. Internal: mode reg, 2-bit prefix index, 8-bit byte counter, timeout counter.
- IDLE: cmd_ready=1. On cmd_valid&cmd_ready: latch mode, clear index/counter, clear timeout flag, go PREFIX.
- PREFIX: tx_valid=1, tx_data=prefix[mode][index]. Each tx handshake increments index; handshake at index 3 → PAYLOAD, counter=0.
- PAYLOAD: combinational pass-through: tx_data=pl_data, tx_valid=pl_valid, pl_ready=tx_ready. Each handshake increments counter; handshake with counter = N_payload−1 → RESP, counter=0, timeout counter=0.
- RESP: resp_data=rx_data, resp_valid=rx_valid, rx_ready=resp_ready, resp_last=(counter = N_resp−1). Each handshake increments counter and clears timeout counter; final handshake → IDLE.
- RESP timeout: timeout counter increments every cycle without an rx handshake; on reaching TIMEOUT_CYCLES−1 → IDLE, timeout flag set. A handshake on that same cycle takes priority (counter cleared, no timeout).
- Outside RESP: rx_ready=1; received bytes are discarded (stray). pl_ready=0 and resp_valid=0 outside their states; tx_valid=0 in IDLE/RESP.
- Simultaneous cmd accept and stray rx byte in IDLE: both occur; the byte is discarded.
- Counters are 8 bits; no wrap within a legal transaction.

## Timing
- Reset: state IDLE, cmd_ready=1, busy=0, tx_valid=0, pl_ready=0, rx_ready=1, resp_valid=0, resp_last=0, timeout=0, stray_count=0, state_dbg=0, tx_data=0, resp_data=0 when not in pass-through.
- Reset mid-transaction aborts immediately; no partial frame continues; timeout not set.
- cmd handshake at cycle t → tx_valid with first prefix byte at t+1.
- Zero-latency pass-through in PAYLOAD/RESP; each state advance takes effect the cycle after the qualifying handshake.
- Minimum transaction with no backpressure: 1 + 4 + N_payload + N_resp cycles, cmd_ready high again the cycle after the last response handshake.

## Configuration
- SCUMV_FRAMER_STRAY_CNT_EN defined: stray_count is an 8-bit saturating (holds at 255) count of rx handshakes outside RESP, cleared only by reset.
- Undefined: stray_count tied to 0; stray bytes still drained (rx_ready=1) and discarded.

## Test plan
- ASC, no backpressure, payload 00..15, receiver returns A5 → tx sees 61 73 63 2B 00..15 (26 bytes); resp A5 with resp_last=1; cmd_ready high 1 cycle later.
- STL, tx_ready toggled every other cycle, resp_ready low 3 cycles per byte → tx 73 74 6C 2B + 16 payload bytes in order; 16 resp bytes, resp_last only on 16th; no byte lost or duplicated.
- STL, TIMEOUT_CYCLES=100, receiver sends 5 bytes then stops → return to IDLE exactly 99 cycles after 5th byte, timeout=1; next cmd accept clears timeout.
- 3 rx bytes in IDLE then ASC transaction, macro defined → stray_count=3, response unaffected; 300 stray bytes → 255; macro undefined → stray_count=0.
- Reset asserted after 7th payload byte → next cycle state_dbg=0, tx_valid=0, pl_ready=0, cmd_ready=1; fresh ASC transaction completes normally.
